// File: rtl/muldiv_stall_ctrl_if.sv
// EX-stage handshake bundle between the pipeline, the multiply/divide units
// and the long-op stall controller.
interface muldiv_stall_ctrl_if;
  logic [4:0] AluControlPort;
  logic       ex_valid;
  logic       flush;
  logic       mul_done;
  logic       div_done;
  logic       Stall;
  logic       mul_aresetn;
  logic       div_aresetn;
  logic       op_done;
  logic       timeout;

  // Pipeline/unit side: drives decode and strobes, observes stall and resets.
  modport master (
    output AluControlPort, ex_valid, flush, mul_done, div_done,
    input  Stall, mul_aresetn, div_aresetn, op_done, timeout
  );

  // Controller side.
  modport slave (
    input  AluControlPort, ex_valid, flush, mul_done, div_done,
    output Stall, mul_aresetn, div_aresetn, op_done, timeout
  );
endinterface

// File: rtl/muldiv_stall_ctrl.sv
// Stall controller for the EX-stage multi-cycle multiplier and divider:
// decodes long ops, owns the unit resets and freezes the pipeline until done.
module muldiv_stall_ctrl #(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned DIV_LATENCY = 71,
  parameter bit          DONE_MODE   = 1'b0
) (
  input logic               clk,
  input logic               resetn,
  muldiv_stall_ctrl_if.slave bus
);

  localparam int unsigned MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] MUL_L   = CNT_W'(MUL_LATENCY);
  localparam logic [CNT_W-1:0] DIV_L   = CNT_W'(DIV_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_is_div_q, op_is_div_d;
  logic             to_pend_q, to_pend_d;
  logic             mul_rstn_q, mul_rstn_d;
  logic             div_rstn_q, div_rstn_d;

  logic             is_long;
  logic             is_div;
  logic             start;
  logic [CNT_W-1:0] start_lat;
  logic             active_done;

  assign is_long   = bus.AluControlPort[4];
  assign is_div    = bus.AluControlPort[4] & bus.AluControlPort[2];
  assign start     = (state_q == IDLE) & bus.ex_valid & is_long & ~bus.flush;
  assign start_lat = is_div ? DIV_L : MUL_L;

  // The inactive unit's strobe never reaches the FSM; in fixed-count mode
  // neither strobe does.
  assign active_done = DONE_MODE & (op_is_div_q ? bus.div_done : bus.mul_done);

  // State register. The unit resets are flopped from the next-state decode so
  // they come straight off a register and cannot glitch.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_is_div_q <= 1'b0;
      to_pend_q   <= 1'b0;
      mul_rstn_q  <= 1'b0;
      div_rstn_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_is_div_q <= op_is_div_d;
      to_pend_q   <= to_pend_d;
      mul_rstn_q  <= mul_rstn_d;
      div_rstn_q  <= div_rstn_d;
    end
  end

  // Next-state logic.
  // NOTE: every signal gets a default before the case so no path can leave a
  // combinational output unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_is_div_d = op_is_div_q;
    to_pend_d   = to_pend_q;

    if (bus.flush) begin
      state_d   = IDLE;
      cnt_d     = '0;
      to_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_is_div_d = is_div;
            to_pend_d   = 1'b0;
            if (start_lat == CNT_ONE) begin
              state_d = DONE;
              cnt_d   = '0;
            end else begin
              state_d = BUSY;
              cnt_d   = start_lat - CNT_ONE;
            end
          end
        end
        BUSY: begin
          if (active_done) begin
            state_d = DONE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_ONE) begin
            // Count exhausted: in done-handshake mode this is a timeout.
            state_d   = DONE;
            cnt_d     = '0;
            to_pend_d = DONE_MODE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        DONE: begin
          // Start is deliberately not evaluated here: the retiring
          // instruction is still in EX and must not launch again.
          state_d   = IDLE;
          to_pend_d = 1'b0;
        end
        default: begin
          state_d   = IDLE;
          cnt_d     = '0;
          to_pend_d = 1'b0;
        end
      endcase
    end

    // A unit is released only while it owns the operation; IDLE (including the
    // start cycle) keeps it in reset so it begins every op from a clean state.
    mul_rstn_d = ((state_d == BUSY) || (state_d == DONE)) && !op_is_div_d;
    div_rstn_d = ((state_d == BUSY) || (state_d == DONE)) &&  op_is_div_d;
  end

  // Output logic. Stall includes the raw start term so the pipeline freezes in
  // the detect cycle itself.
  always_comb begin
    bus.Stall       = start | (state_q == BUSY);
    bus.mul_aresetn = mul_rstn_q;
    bus.div_aresetn = div_rstn_q;
    bus.op_done     = (state_q == DONE) & ~bus.flush;
    bus.timeout     = (state_q == DONE) & to_pend_q & ~bus.flush;
  end

endmodule
